// File: rtl/fpu_exec_unit.sv
// Multicycle FP add/sub/mul/move execute stage, IEEE single and half formats.
// Round toward zero, denormals flushed to zero, one result per accepted start.
module fpu_exec_unit #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        single,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  // state    | meaning
  // S_IDLE   | waiting for start; operands captured on accept
  // S_UNPACK | split sign/exponent/mantissa, classify zero and inf
  // S_EXEC   | align and add/sub, or multiply mantissas
  // S_NORM   | leading-one normalise, exponent adjust
  // S_PACK   | special cases and final packing
  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_EXEC, S_NORM, S_PACK} state_t;

  localparam logic [1:0] OP_SUB = 2'b01, OP_MUL = 2'b10, OP_MOV = 2'b11;
  localparam logic [1:0] SP_NONE = 2'd0, SP_NAN = 2'd1, SP_INF = 2'd2, SP_ZERO = 2'd3;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic               single_q, single_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               za_q, za_d, zb_q, zb_d, ia_q, ia_d, ib_q, ib_d;
  logic [7:0]         ea_q, ea_d, eb_q, eb_d;
  logic [23:0]        ma_q, ma_d, mb_q, mb_d;
  logic               sign_q, sign_d, spsign_q, spsign_d;
  logic [1:0]         spec_q, spec_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [47:0]        mant_q, mant_d;
  logic [31:0]        result_q, result_d;
  logic               done_q, done_d;

  function automatic logic [31:0] inf_word(input logic s, input logic sgl);
    return sgl ? {s, 8'hFF, 23'b0} : {16'b0, s, 5'h1F, 10'b0};
  endfunction

  function automatic logic [31:0] zero_word(input logic s, input logic sgl);
    return sgl ? {s, 31'b0} : {16'b0, s, 15'b0};
  endfunction

  // Half mantissas are left-aligned to the single layout so one datapath serves both.
  logic [7:0]  ea_raw, eb_raw, emax;
  logic [22:0] fa_raw, fb_raw;
  logic        sa_raw, sb_raw;
  always_comb begin
    if (single_q) begin
      sa_raw = a_q[31]; ea_raw = a_q[30:23]; fa_raw = a_q[22:0];
      sb_raw = b_q[31]; eb_raw = b_q[30:23]; fb_raw = b_q[22:0];
      emax   = 8'hFF;
    end else begin
      sa_raw = a_q[15]; ea_raw = {3'b0, a_q[14:10]}; fa_raw = {a_q[9:0], 13'b0};
      sb_raw = b_q[15]; eb_raw = {3'b0, b_q[14:10]}; fb_raw = {b_q[9:0], 13'b0};
      emax   = 8'h1F;
    end
  end

  logic               a_big, sl;
  logic [7:0]         el, es, diff;
  logic [23:0]        ml, ms, ms_sh;
  logic [24:0]        sum;
  logic [47:0]        prod;
  logic signed [9:0]  bias;
  always_comb begin
    a_big = {ea_q, ma_q} >= {eb_q, mb_q};
    el    = a_big ? ea_q : eb_q;
    es    = a_big ? eb_q : ea_q;
    ml    = a_big ? ma_q : mb_q;
    ms    = a_big ? mb_q : ma_q;
    sl    = a_big ? sa_q : sb_q;
    diff  = el - es;
    ms_sh = (diff > 8'd25) ? '0 : (ms >> diff);
    // bits shifted below the half mantissa width are lost, as in a native 11-bit datapath
    if (!single_q) ms_sh[12:0] = '0;
    sum   = (sa_q ^ sb_q) ? ({1'b0, ml} - {1'b0, ms_sh}) : ({1'b0, ml} + {1'b0, ms_sh});
    prod  = {24'b0, ma_q} * {24'b0, mb_q};
    bias  = single_q ? 10'sd127 : 10'sd15;
  end

  // Normalised mantissa keeps its hidden one at bit 46.
  logic [5:0]         lead, nsh;
  logic [47:0]        mant_n;
  logic signed [9:0]  exp_n;
  always_comb begin
    lead = '0;
    for (int i = 0; i < 48; i++) begin
      if (mant_q[i]) lead = 6'(i);
    end
    nsh    = 6'd46 - lead;
    mant_n = mant_q;
    exp_n  = exp_q;
    if (mant_q[47]) begin
      mant_n = mant_q >> 1;
      exp_n  = exp_q + 10'sd1;
    end else if (mant_q != '0) begin
      mant_n = mant_q << nsh;
      exp_n  = exp_q - $signed({4'b0, nsh});
    end
  end

  logic signed [9:0] emax_s;
  logic [31:0]       res_pk;
  always_comb begin
    emax_s = single_q ? 10'sd255 : 10'sd31;
    res_pk = '0;
    if (op_q == OP_MOV)              res_pk = a_q;
    else if (spec_q == SP_NAN)       res_pk = single_q ? 32'h7FC0_0000 : 32'h0000_7E00;
    else if (spec_q == SP_INF)       res_pk = inf_word(spsign_q, single_q);
    else if (spec_q == SP_ZERO)      res_pk = zero_word(spsign_q, single_q);
    else if (!mant_q[46])            res_pk = '0;
    else if (exp_q >= emax_s)        res_pk = inf_word(sign_q, single_q);
    else if (exp_q <= 10'sd0)        res_pk = zero_word(sign_q, single_q);
    else if (single_q)               res_pk = {sign_q, exp_q[7:0], mant_q[45:23]};
    else                             res_pk = {16'b0, sign_q, exp_q[4:0], mant_q[45:36]};
  end

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;
    a_d = a_q;  b_d = b_q;  op_d = op_q;  single_d = single_q;
    sa_d = sa_q;  sb_d = sb_q;  za_d = za_q;  zb_d = zb_q;  ia_d = ia_q;  ib_d = ib_q;
    ea_d = ea_q;  eb_d = eb_q;  ma_d = ma_q;  mb_d = mb_q;
    sign_d = sign_q;  spsign_d = spsign_q;  spec_d = spec_q;
    exp_d = exp_q;  mant_d = mant_q;
    result_d = result_q;  done_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_UNPACK;
        cnt_d    = 3'(LAT - 1);
        a_d      = single ? a : {16'b0, a[15:0]};
        b_d      = single ? b : {16'b0, b[15:0]};
        op_d     = op;
        single_d = single;
      end
      S_UNPACK: begin
        state_d = S_EXEC;
        cnt_d   = cnt_q - 3'd1;
        sa_d    = sa_raw;
        sb_d    = sb_raw ^ (op_q == OP_SUB);
        ea_d    = ea_raw;
        eb_d    = eb_raw;
        ma_d    = (ea_raw != '0) ? {1'b1, fa_raw} : '0;
        mb_d    = (eb_raw != '0) ? {1'b1, fb_raw} : '0;
        za_d    = (ea_raw == '0);
        zb_d    = (eb_raw == '0);
        ia_d    = (ea_raw == emax);
        ib_d    = (eb_raw == emax);
      end
      S_EXEC: begin
        state_d  = S_NORM;
        cnt_d    = cnt_q - 3'd1;
        spec_d   = SP_NONE;
        spsign_d = 1'b0;
        if (op_q == OP_MUL) begin
          sign_d   = sa_q ^ sb_q;
          spsign_d = sa_q ^ sb_q;
          exp_d    = $signed({2'b0, ea_q}) + $signed({2'b0, eb_q}) - bias;
          mant_d   = prod;
          if ((ia_q && zb_q) || (za_q && ib_q)) spec_d = SP_NAN;
          else if (ia_q || ib_q)                spec_d = SP_INF;
          else if (za_q || zb_q)                spec_d = SP_ZERO;
        end else begin
          sign_d = sl;
          exp_d  = $signed({2'b0, el});
          mant_d = {sum, 23'b0};
          if (ia_q && ib_q && (sa_q != sb_q)) spec_d = SP_NAN;
          else if (ia_q) begin spec_d = SP_INF; spsign_d = sa_q; end
          else if (ib_q) begin spec_d = SP_INF; spsign_d = sb_q; end
        end
      end
      S_NORM: begin
        state_d = S_PACK;
        cnt_d   = cnt_q - 3'd1;
        mant_d  = mant_n;
        exp_d   = exp_n;
      end
      S_PACK: if (cnt_q == '0) begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        result_d = res_pk;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;  cnt_q <= '0;
      a_q <= '0;  b_q <= '0;  op_q <= '0;  single_q <= 1'b0;
      sa_q <= 1'b0;  sb_q <= 1'b0;  za_q <= 1'b0;  zb_q <= 1'b0;  ia_q <= 1'b0;  ib_q <= 1'b0;
      ea_q <= '0;  eb_q <= '0;  ma_q <= '0;  mb_q <= '0;
      sign_q <= 1'b0;  spsign_q <= 1'b0;  spec_q <= SP_NONE;
      exp_q <= '0;  mant_q <= '0;
      result_q <= '0;  done_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;
      a_q <= a_d;  b_q <= b_d;  op_q <= op_d;  single_q <= single_d;
      sa_q <= sa_d;  sb_q <= sb_d;  za_q <= za_d;  zb_q <= zb_d;  ia_q <= ia_d;  ib_q <= ib_d;
      ea_q <= ea_d;  eb_q <= eb_d;  ma_q <= ma_d;  mb_q <= mb_d;
      sign_q <= sign_d;  spsign_q <= spsign_d;  spec_q <= spec_d;
      exp_q <= exp_d;  mant_q <= mant_d;
      result_q <= result_d;  done_q <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_fpu_exec_unit.sv
// Scoreboard bench for fpu_exec_unit: stimulus pushes expected result and due cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_fpu_exec_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        single = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] result;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  fpu_exec_unit #(.LAT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .single(single),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endfunction

  function automatic void expect_res(input string nm, input logic [31:0] r, input int due);
    exp_t e;
    e.res  = r;
    e.due  = due;
    e.name = nm;
    sb_q.push_back(e);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_latency"}, cyc, e.due);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic s, input logic [31:0] aa,
                       input logic [31:0] bb, output int k);
    @(negedge clk);
    k = cyc;
    start = 1'b1; op = o; single = s; a = aa; b = bb;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb_q.size(), 32'd0);
    sb_q.delete();
  endtask

  task automatic run_vec(input string nm, input logic [1:0] o, input logic s,
                         input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] r);
    int k;
    @(negedge clk);
    k = cyc;
    start = 1'b1; op = o; single = s; a = aa; b = bb;
    expect_res(nm, r, k + 5);
    @(negedge clk);
    start = 1'b0;
    wait_drain();
  endtask

  initial begin : stim
    int k;
    #12;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // busy profile: high for the four cycles after accept, low in the done cycle
    @(negedge clk);
    k = cyc;
    start = 1'b1; op = 2'b00; single = 1'b1; a = 32'h3F80_0000; b = 32'h4000_0000;
    expect_res("single_add", 32'h4040_0000, k + 5);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("busy_cycle%0d", i), {31'b0, busy}, (i < 5) ? 32'd1 : 32'd0);
    end
    wait_drain();

    run_vec("half_mul",       2'b10, 1'b0, 32'hABCD_3E00, 32'h1234_4000, 32'h0000_4200);
    run_vec("sub_exact_zero", 2'b01, 1'b1, 32'h40A0_0000, 32'h40A0_0000, 32'h0000_0000);
    run_vec("add_truncate",   2'b00, 1'b1, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    run_vec("add_neg",        2'b00, 1'b1, 32'hBF80_0000, 32'h3F00_0000, 32'hBF00_0000);
    run_vec("mul_overflow",   2'b10, 1'b1, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000);
    run_vec("half_inf_x_0",   2'b10, 1'b0, 32'h0000_7C00, 32'h0000_0000, 32'h0000_7E00);
    run_vec("inf_minus_inf",  2'b00, 1'b1, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    run_vec("mul_underflow",  2'b10, 1'b1, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
    run_vec("half_move",      2'b11, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_5678);
    run_vec("half_sub_upper", 2'b01, 1'b0, 32'hFFFF_4200, 32'h0000_3C00, 32'h0000_4000);
    run_vec("neg_inf_add",    2'b00, 1'b1, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);

    // start pulse while busy must be dropped
    issue(2'b10, 1'b1, 32'h4000_0000, 32'h4040_0000, k);
    expect_res("busy_ignore", 32'h40C0_0000, k + 5);
    @(negedge clk);
    start = 1'b1; op = 2'b11; single = 1'b1; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (8) @(negedge clk);
    chk("busy_after_ignore", {31'b0, busy}, 32'd0);

    // start held through the done cycle: second op accepted at the edge ending it
    @(negedge clk);
    k = cyc;
    start = 1'b1; op = 2'b10; single = 1'b1; a = 32'h4000_0000; b = 32'h4040_0000;
    expect_res("held_first", 32'h40C0_0000, k + 5);
    repeat (5) @(negedge clk);
    chk("held_done_cycle", {31'b0, done}, 32'd1);
    op = 2'b01; a = 32'h4040_0000; b = 32'h3F80_0000;
    expect_res("held_second", 32'h4000_0000, k + 10);
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // reset two cycles into an operation aborts it without a done pulse
    issue(2'b00, 1'b0, 32'h0000_3C00, 32'h0000_3C00, k);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_no_busy", {31'b0, busy}, 32'd0);
    run_vec("post_reset_add", 2'b00, 1'b0, 32'h0000_3C00, 32'h0000_3C00, 32'h0000_4000);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #50000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d expected 0", sb_q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
